// File: rtl/video_timing_pkg.sv
`default_nettype none
//==============================================================================
// Module  : video_timing_pkg
// Purpose : 720p timing defaults, line/frame total derivation, colour-bar table.
// Revision: 1.0
//==============================================================================
package video_timing_pkg;

  localparam int CNT_W = 12;
  localparam int PIX_W = 24;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [PIX_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [PIX_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [PIX_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [PIX_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [PIX_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [PIX_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [PIX_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic int calc_h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int calc_v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Smallest column whose bar index floor(x*8/active) reaches k.
  function automatic int bar_boundary(input int k, input int active);
    return (k * active + 7) / 8;
  endfunction

  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`default_nettype none
//==============================================================================
// Module  : video_timing_gen_if
// Purpose : Frame-buffer request/data and transmitter video signals.
//           pattern_sel exists only when VIDEO_TEST_PATTERN_EN is defined.
// Revision: 1.0
//==============================================================================
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic             enable;
  logic             pixel_rd_req;
  logic [CNT_W-1:0] pixel_xpos;
  logic [CNT_W-1:0] pixel_ypos;
  logic [PIX_W-1:0] pixel_data;
  logic             frame_start;
  logic [PIX_W-1:0] video_din;
  logic             video_hsync;
  logic             video_vsync;
  logic             video_de;
`ifdef VIDEO_TEST_PATTERN_EN
  logic             pattern_sel;
`endif

  modport master (
`ifdef VIDEO_TEST_PATTERN_EN
    input  pattern_sel,
`endif
    input  enable, pixel_data,
    output pixel_rd_req, pixel_xpos, pixel_ypos, frame_start,
    output video_din, video_hsync, video_vsync, video_de
  );

  modport slave (
`ifdef VIDEO_TEST_PATTERN_EN
    output pattern_sel,
`endif
    output enable, pixel_data,
    input  pixel_rd_req, pixel_xpos, pixel_ypos, frame_start,
    input  video_din, video_hsync, video_vsync, video_de
  );

endinterface
`default_nettype wire

// File: rtl/video_sync_pipe.sv
`default_nettype none
//==============================================================================
// Module  : video_sync_pipe
// Purpose : Two-stage delay for de/hsync/vsync; resets to inactive levels.
// Revision: 1.0
//==============================================================================
module video_sync_pipe #(
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic pclk,
  input  logic reset,
  input  logic de_i,
  input  logic hs_i,
  input  logic vs_i,
  output logic de_s1_o,
  output logic de_o,
  output logic hs_o,
  output logic vs_o
);

  logic de_s1_q, hs_s1_q, vs_s1_q;
  logic de_s2_q, hs_s2_q, vs_s2_q;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      de_s1_q <= 1'b0;
      hs_s1_q <= ~HS_POL;
      vs_s1_q <= ~VS_POL;
      de_s2_q <= 1'b0;
      hs_s2_q <= ~HS_POL;
      vs_s2_q <= ~VS_POL;
    end else begin
      de_s1_q <= de_i;
      hs_s1_q <= hs_i;
      vs_s1_q <= vs_i;
      de_s2_q <= de_s1_q;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
    end
  end

  assign de_s1_o = de_s1_q;
  assign de_o    = de_s2_q;
  assign hs_o    = hs_s2_q;
  assign vs_o    = vs_s2_q;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module  : video_timing_gen
// Purpose : Video timing counters, frame-buffer fetch and aligned video output.
//           VIDEO_TEST_PATTERN_EN adds an 8-bar colour pattern source.
// Revision: 1.0
//==============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic               pclk,
  input  logic               reset,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  logic             run_d, de_d, rd_req_d, fs_d, hs_lvl_d, vs_lvl_d;
  logic             rd_req_q, fs_q, de_raw_q, hs_raw_q, vs_raw_q;
  logic [CNT_W-1:0] xpos_q, ypos_q;

  logic             de_s1, de_s2, hs_s2, vs_s2;
  logic [PIX_W-1:0] din_q, din_d;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      ST_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (vif.enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            // Only the frame boundary may return to IDLE, so frames are never cut short.
            v_cnt_d = '0;
            if (!vif.enable) state_d = ST_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 12'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from next-state values so every request output comes straight from a flop.
  always_comb begin
    run_d    = (state_d == ST_RUN);
    de_d     = run_d && (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    fs_d     = run_d && (h_cnt_d == '0) && (v_cnt_d == '0);
    hs_lvl_d = (run_d && (h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? HS_POL : ~HS_POL;
    vs_lvl_d = (run_d && (v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? VS_POL : ~VS_POL;
`ifdef VIDEO_TEST_PATTERN_EN
    rd_req_d = de_d && !vif.pattern_sel;
`else
    rd_req_d = de_d;
`endif
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      rd_req_q <= 1'b0;
      fs_q     <= 1'b0;
      xpos_q   <= '0;
      ypos_q   <= '0;
      de_raw_q <= 1'b0;
      hs_raw_q <= ~HS_POL;
      vs_raw_q <= ~VS_POL;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      rd_req_q <= rd_req_d;
      fs_q     <= fs_d;
      xpos_q   <= rd_req_d ? h_cnt_d : '0;
      ypos_q   <= rd_req_d ? v_cnt_d : '0;
      de_raw_q <= de_d;
      hs_raw_q <= hs_lvl_d;
      vs_raw_q <= vs_lvl_d;
      din_q    <= din_d;
    end
  end

  video_sync_pipe #(
    .HS_POL (HS_POL),
    .VS_POL (VS_POL)
  ) u_sync_pipe (
    .pclk    (pclk),
    .reset   (reset),
    .de_i    (de_raw_q),
    .hs_i    (hs_raw_q),
    .vs_i    (vs_raw_q),
    .de_s1_o (de_s1),
    .de_o    (de_s2),
    .hs_o    (hs_s2),
    .vs_o    (vs_s2)
  );

`ifdef VIDEO_TEST_PATTERN_EN
  logic [6:0] bar_ge;
  logic [2:0] bar_idx;
  logic [2:0] bar_q;
  logic       pat_raw_q, pat_s1_q;

  for (genvar k = 1; k < 8; k++) begin : g_bar
    localparam logic [CNT_W-1:0] BOUND = CNT_W'(bar_boundary(k, H_ACTIVE));
    assign bar_ge[k-1] = (h_cnt_q >= BOUND);
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 0; k < 7; k++) begin
      if (bar_ge[k]) bar_idx = bar_idx + 3'd1;
    end
  end

  // Pattern select rides alongside de so the bar colour lands in the same slot as fetched data.
  always_ff @(posedge pclk) begin
    if (!reset) begin
      pat_raw_q <= 1'b0;
      pat_s1_q  <= 1'b0;
      bar_q     <= '0;
    end else begin
      pat_raw_q <= vif.pattern_sel;
      pat_s1_q  <= pat_raw_q;
      bar_q     <= bar_idx;
    end
  end

  always_comb begin
    din_d = '0;
    if (de_s1) din_d = pat_s1_q ? bar_color(bar_q) : vif.pixel_data;
  end
`else
  always_comb begin
    din_d = '0;
    if (de_s1) din_d = vif.pixel_data;
  end
`endif

  assign vif.pixel_rd_req = rd_req_q;
  assign vif.pixel_xpos   = xpos_q;
  assign vif.pixel_ypos   = ypos_q;
  assign vif.frame_start  = fs_q;
  assign vif.video_din    = din_q;
  assign vif.video_de     = de_s2;
  assign vif.video_hsync  = hs_s2;
  assign vif.video_vsync  = vs_s2;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module  : tb_video_timing_gen
// Purpose : Directed bench for video_timing_gen on a 24x8 timing, scoreboarded.
//           Exercises the pattern source when VIDEO_TEST_PATTERN_EN is defined.
// Revision: 1.0
//==============================================================================
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] din;
  } vid_t;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  video_timing_gen_if vif ();

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .vif   (vif)
  );

  // Frame buffer: returns the requested column one cycle later, filler otherwise.
  always @(posedge pclk) begin
    vif.pixel_data <= vif.pixel_rd_req ? {12'h000, vif.pixel_xpos} : 24'hA5A5A5;
  end

  vid_t sb[$];
  bit   mrun;
  int   mh, mv;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [23:0] exp_bar(input int x);
    case (x * 8 / HA)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic en_s, rst_s, pat_s, de, hsa, vsa, rd, fs;
    vid_t ent, expv, obsv;
    en_s  = vif.enable;
    rst_s = reset;
    pat_s = 1'b0;
`ifdef VIDEO_TEST_PATTERN_EN
    pat_s = vif.pattern_sel;
`endif
    @(posedge pclk);
    #1;
    cyc++;
    if (!rst_s) begin
      mrun = 1'b0; mh = 0; mv = 0;
      sb.delete();
      sb.push_back('0);
      sb.push_back('0);
    end else if (!mrun) begin
      mh = 0; mv = 0; mrun = en_s;
    end else if (mh == HT - 1) begin
      mh = 0;
      if (mv == VT - 1) begin
        mv = 0;
        if (!en_s) mrun = 1'b0;
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
    de  = mrun && (mh < HA) && (mv < VA);
    hsa = mrun && (mh >= HA + HF) && (mh < HA + HF + HS);
    vsa = mrun && (mv >= VA + VF) && (mv < VA + VF + VS);
    rd  = de && !pat_s;
    fs  = mrun && (mh == 0) && (mv == 0);
    ent.de  = de;
    ent.hs  = hsa;
    ent.vs  = vsa;
    ent.din = !de ? 24'h0 : (pat_s ? exp_bar(mh) : 24'(mh));
    sb.push_back(ent);
    expv = sb.pop_front();
    chk("req", {38'h0, vif.pixel_rd_req, vif.frame_start, vif.pixel_xpos, vif.pixel_ypos},
        {38'h0, rd, fs, rd ? 12'(mh) : 12'h0, rd ? 12'(mv) : 12'h0});
    obsv = {vif.video_de, vif.video_hsync, vif.video_vsync, vif.video_din};
    chk("video", 64'(obsv), 64'(expv));
  endtask

  initial begin
    int de_cnt, vs_cnt, hs_cnt, fs_cnt, rd_cnt;
    reset = 1'b0;
    vif.enable = 1'b0;
`ifdef VIDEO_TEST_PATTERN_EN
    vif.pattern_sel = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Two full frames; windows are shifted by the 2-cycle output latency.
    vif.enable = 1'b1;
    de_cnt = 0; vs_cnt = 0; hs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick();
      fs_cnt += int'(vif.frame_start);
      if (i >= 2 && i < 2 + HT * VT) begin
        de_cnt += int'(vif.video_de);
        vs_cnt += int'(vif.video_vsync);
      end
      if (i >= 2 && i < 2 + HT) hs_cnt += int'(vif.video_hsync);
    end
    chk("de_per_frame", 64'(de_cnt), 64'd64);
    chk("vs_per_frame", 64'(vs_cnt), 64'd48);
    chk("hs_per_line", 64'(hs_cnt), 64'd3);
    chk("fs_two_frames", 64'(fs_cnt), 64'd2);

    // Drop enable at the start of line 2; the frame must complete before IDLE.
    repeat (2 * HT) tick();
    vif.enable = 1'b0;
    repeat (HT * VT - 2 * HT + 16) tick();
    chk("idle_after_drop", {61'h0, vif.pixel_rd_req, vif.video_de, vif.frame_start}, 64'h0);

    vif.enable = 1'b1;
    repeat (HT + 6) tick();

    // Reset in the middle of an active line.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (HT + 8) tick();

`ifdef VIDEO_TEST_PATTERN_EN
    vif.pattern_sel = 1'b1;
    rd_cnt = 0;
    repeat (HT * VT + 4) begin
      tick();
      rd_cnt += int'(vif.pixel_rd_req);
    end
    chk("pattern_no_req", 64'(rd_cnt), 64'd0);
    vif.pattern_sel = 1'b0;
    repeat (HT) tick();
`else
    rd_cnt = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
